// File: rtl/sa_tile_feeder.sv
// Tile sequencer for SystolicArrayv1. It buffers one weight column and a block of activation rows per K-slice.
// It loads the weights serially, streams skewed activations, drains the array and returns one result row set.
module sa_tile_feeder #(
  parameter int BN_NUM   = 5,
  parameter int ACCU_NUM = 5,
  parameter int BW_ACT   = 8,
  parameter int BW_WET   = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [7:0]                 cfg_k_tiles,
  input  logic [7:0]                 cfg_shift_num,
  input  logic                       wet_valid,
  output logic                       wet_ready,
  input  logic [BW_WET-1:0]          wet_data,
  input  logic                       act_valid,
  output logic                       act_ready,
  input  logic [ACCU_NUM*BW_ACT-1:0] act_data,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [BN_NUM*BW_ACT-1:0]   res_data,
  output logic                       busy,
  output logic                       PE_mac_enable,
  output logic                       PE_clear_acc,
  output logic                       PE_weight_partial_sel,
  output logic [BW_WET-1:0]          PE_wet_in,
  output logic [ACCU_NUM*BW_ACT-1:0] PE_act_in,
  output logic [7:0]                 PE_res_shift_num,
  input  logic [BN_NUM*BW_ACT-1:0]   PE_result_out
);

  localparam int CW  = $clog2(BN_NUM + ACCU_NUM + 1);
  localparam int WCW = $clog2(ACCU_NUM + 1);
  localparam int ACW = $clog2(BN_NUM + 1);

  localparam logic [CW-1:0]  LOAD_LAST   = CW'(ACCU_NUM);
  localparam logic [CW-1:0]  STREAM_LAST = CW'(BN_NUM + ACCU_NUM - 1);
  localparam logic [CW-1:0]  DRAIN_LAST  = CW'(3);
  localparam logic [WCW-1:0] WET_FULL    = WCW'(ACCU_NUM);
  localparam logic [ACW-1:0] ACT_FULL    = ACW'(BN_NUM);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] LOAD_W = 3'd2;
  localparam logic [2:0] STREAM = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;
  localparam logic [2:0] CLR    = 3'd5;
  localparam logic [2:0] CAP    = 3'd6;
  localparam logic [2:0] RESP   = 3'd7;

  logic [2:0]     state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [7:0]     slice_r, slice_s;
  logic [7:0]     k_tiles_r;
  logic [WCW-1:0] wet_cnt_r, wet_cnt_s;
  logic [ACW-1:0] act_cnt_r, act_cnt_s;
  logic           wet_acc_s, act_acc_s;

  logic [BW_WET-1:0]          wet_buf_r [ACCU_NUM];
  logic [ACCU_NUM*BW_ACT-1:0] act_buf_r [BN_NUM];

  logic                       wet_ready_r, act_ready_r, res_valid_r, busy_r;
  logic                       mac_en_r, clear_acc_r, wsel_r;
  logic [BW_WET-1:0]          wet_in_r;
  logic [ACCU_NUM*BW_ACT-1:0] act_in_r;
  logic [7:0]                 shift_r;
  logic [BN_NUM*BW_ACT-1:0]   res_data_r;

  logic                       wet_ready_s, act_ready_s, res_valid_s, busy_s;
  logic                       mac_en_s, clear_acc_s, wsel_s;
  logic [BW_WET-1:0]          wet_in_s;
  logic [ACCU_NUM*BW_ACT-1:0] act_in_s;

  assign wet_ready             = wet_ready_r;
  assign act_ready             = act_ready_r;
  assign res_valid             = res_valid_r;
  assign res_data              = res_data_r;
  assign busy                  = busy_r;
  assign PE_mac_enable         = mac_en_r;
  assign PE_clear_acc          = clear_acc_r;
  assign PE_weight_partial_sel = wsel_r;
  assign PE_wet_in             = wet_in_r;
  assign PE_act_in             = act_in_r;
  assign PE_res_shift_num      = shift_r;

  // Next-state, phase counter, slice counter and fetch fill levels.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    slice_s   = slice_r;
    wet_cnt_s = wet_cnt_r;
    act_cnt_s = act_cnt_r;
    wet_acc_s = wet_valid & wet_ready_r;
    act_acc_s = act_valid & act_ready_r;
    case (state_r)
      IDLE: begin
        if (start && (cfg_k_tiles != 8'd0)) begin
          state_s   = FETCH;
          slice_s   = 8'd0;
          wet_cnt_s = '0;
          act_cnt_s = '0;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (wet_acc_s) begin
          wet_cnt_s = wet_cnt_r + WCW'(1);
        end else begin
          wet_cnt_s = wet_cnt_r;
        end
        if (act_acc_s) begin
          act_cnt_s = act_cnt_r + ACW'(1);
        end else begin
          act_cnt_s = act_cnt_r;
        end
        if ((wet_cnt_s == WET_FULL) && (act_cnt_s == ACT_FULL)) begin
          state_s = LOAD_W;
          cnt_s   = '0;
        end else begin
          state_s = FETCH;
        end
      end
      LOAD_W: begin
        if (cnt_r == LOAD_LAST) begin
          state_s = STREAM;
          cnt_s   = CW'(1);
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      STREAM: begin
        if (cnt_r == STREAM_LAST) begin
          slice_s = slice_r + 8'd1;
          if (slice_s < k_tiles_r) begin
            state_s   = FETCH;
            wet_cnt_s = '0;
            act_cnt_s = '0;
          end else begin
            state_s = DRAIN;
            cnt_s   = CW'(1);
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          state_s = CLR;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      CLR:  state_s = CAP;
      CAP:  state_s = RESP;
      RESP: begin
        if (res_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output values derived from the upcoming state so every output is a flop aligned with its state.
  always_comb begin
    wet_ready_s = (state_s == FETCH) && (wet_cnt_s != WET_FULL);
    act_ready_s = (state_s == FETCH) && (act_cnt_s != ACT_FULL);
    res_valid_s = (state_s == RESP);
    busy_s      = (state_s != IDLE);
    mac_en_s    = (state_s == LOAD_W) || (state_s == STREAM) || (state_s == DRAIN) ||
                  (state_s == CLR) || (state_s == CAP);
    clear_acc_s = !((state_s == LOAD_W) || (state_s == STREAM) || (state_s == DRAIN) ||
                    ((state_s == FETCH) && (slice_s != 8'd0)));
    wsel_s      = !((state_s == STREAM) || (state_s == DRAIN));
    if ((state_s == LOAD_W) && (cnt_s != '0)) begin
      wet_in_s = wet_buf_r[WCW'(LOAD_LAST - cnt_s)];
    end else begin
      wet_in_s = wet_in_r;
    end
    act_in_s = '0;
    if (state_s == STREAM) begin
      // Lane idx trails lane 0 by idx cycles, giving the diagonal wavefront.
      for (int idx = 0; idx < ACCU_NUM; idx++) begin
        if ((cnt_s > CW'(idx)) && ((cnt_s - CW'(idx) - CW'(1)) < CW'(BN_NUM))) begin
          act_in_s[idx*BW_ACT +: BW_ACT] =
            act_buf_r[ACW'(cnt_s - CW'(idx) - CW'(1))][idx*BW_ACT +: BW_ACT];
        end else begin
          act_in_s[idx*BW_ACT +: BW_ACT] = '0;
        end
      end
    end else begin
      act_in_s = '0;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      slice_r     <= 8'd0;
      k_tiles_r   <= 8'd0;
      wet_cnt_r   <= '0;
      act_cnt_r   <= '0;
      wet_ready_r <= 1'b0;
      act_ready_r <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      mac_en_r    <= 1'b0;
      clear_acc_r <= 1'b1;
      wsel_r      <= 1'b1;
      wet_in_r    <= '0;
      act_in_r    <= '0;
      shift_r     <= 8'd0;
      res_data_r  <= '0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      slice_r     <= slice_s;
      wet_cnt_r   <= wet_cnt_s;
      act_cnt_r   <= act_cnt_s;
      wet_ready_r <= wet_ready_s;
      act_ready_r <= act_ready_s;
      res_valid_r <= res_valid_s;
      busy_r      <= busy_s;
      mac_en_r    <= mac_en_s;
      clear_acc_r <= clear_acc_s;
      wsel_r      <= wsel_s;
      wet_in_r    <= wet_in_s;
      act_in_r    <= act_in_s;
      if ((state_r == IDLE) && (state_s == FETCH)) begin
        k_tiles_r <= cfg_k_tiles;
        shift_r   <= cfg_shift_num;
      end
      if (state_r == CAP) begin
        res_data_r <= PE_result_out;
      end
    end
  end

  // Slice buffers: weight k lands in slot k, activation row r in slot r.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ACCU_NUM; i++) begin
        wet_buf_r[i] <= '0;
      end
      for (int i = 0; i < BN_NUM; i++) begin
        act_buf_r[i] <= '0;
      end
    end else begin
      if (wet_acc_s) begin
        wet_buf_r[wet_cnt_r] <= wet_data;
      end
      if (act_acc_s) begin
        act_buf_r[act_cnt_r] <= act_data;
      end
    end
  end

endmodule
